// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite attribute register file: command codes,
// commit state encoding and the per-sprite attribute record.
package sprite_pkg;

    localparam logic [3:0] CMD_NOP     = 4'h0;
    localparam logic [3:0] CMD_SELECT  = 4'h1;
    localparam logic [3:0] CMD_SET_X   = 4'h2;
    localparam logic [3:0] CMD_SET_Y   = 4'h3;
    localparam logic [3:0] CMD_SET_EN  = 4'h4;
    localparam logic [3:0] CMD_SET_IMG = 4'h5;
    localparam logic [3:0] CMD_COMMIT  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COPY
    } commit_state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
        logic [3:0] img;
    } sprite_attr_t;

endpackage

// File: rtl/sprite_commit_fsm.sv
// Commit sequencer: waits for a vblank rising edge after COMMIT, then walks
// cidx over every sprite slot, one copy per cycle.
module sprite_commit_fsm
    import sprite_pkg::*;
#(
    parameter  int unsigned NUM_SPRITES = 8,
    localparam int unsigned IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit,
    input  logic             vblank,
    output logic             copy_we,
    output logic [IDX_W-1:0] cidx,
    output logic             commit_pending,
    output logic             copy_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    commit_state_e state;
    logic          rearm;
    logic          vblank_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cidx     <= '0;
            rearm    <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
            case (state)
                IDLE: begin
                    if (commit) state <= ARMED;
                end
                ARMED: begin
                    if (vblank && !vblank_q) begin
                        state <= COPY;
                        cidx  <= '0;
                    end
                end
                COPY: begin
                    cidx <= cidx + 1'b1;
                    if (cidx == LAST_IDX) begin
                        // A COMMIT landing on the final copy cycle still re-arms.
                        state <= (rearm || commit) ? ARMED : IDLE;
                        rearm <= 1'b0;
                    end else if (commit) begin
                        rearm <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign copy_we        = (state == COPY);
    assign copy_busy      = (state == COPY);
    assign commit_pending = (state != IDLE) || rearm;

endmodule

// File: rtl/sprite_regs.sv
// Sprite attribute register file: shadow table written by commands, copied to
// the active table during vblank. Optional SPRITE_REGS_AUTOINC_EN advances sel after SET_IMG.
module sprite_regs
    import sprite_pkg::*;
#(
    parameter  int unsigned NUM_SPRITES = 8,
    localparam int unsigned IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_write,
    input  logic [3:0]       in_command,
    input  logic [9:0]       in_data,
    input  logic             vblank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [9:0]       rd_x,
    output logic [9:0]       rd_y,
    output logic             rd_en,
    output logic [3:0]       rd_img,
    output logic             commit_pending,
    output logic             copy_busy
);

    sprite_attr_t     shadow [NUM_SPRITES];
    sprite_attr_t     active [NUM_SPRITES];
    sprite_attr_t     rd_q;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cidx;
    logic             copy_we;
    logic             commit;

    assign commit = in_write && (in_command == CMD_COMMIT);

    sprite_commit_fsm #(
        .NUM_SPRITES(NUM_SPRITES)
    ) u_commit_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .commit        (commit),
        .vblank        (vblank),
        .copy_we       (copy_we),
        .cidx          (cidx),
        .commit_pending(commit_pending),
        .copy_busy     (copy_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel <= '0;
            for (int unsigned i = 0; i < NUM_SPRITES; i++) shadow[i] <= '0;
        end else if (in_write) begin
            case (in_command)
                CMD_SELECT: sel            <= in_data[IDX_W-1:0];
                CMD_SET_X:  shadow[sel].x  <= in_data;
                CMD_SET_Y:  shadow[sel].y  <= in_data;
                CMD_SET_EN: shadow[sel].en <= in_data[0];
                CMD_SET_IMG: begin
                    shadow[sel].img <= in_data[3:0];
`ifdef SPRITE_REGS_AUTOINC_EN
                    sel <= sel + 1'b1;
`endif
                end
                CMD_NOP, CMD_COMMIT: ;
                default: ;
            endcase
        end
    end

    // Copy reads shadow before this edge's write lands, so a same-index write stays shadow-only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) active[i] <= '0;
        end else if (copy_we) begin
            active[cidx] <= shadow[cidx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= active[rd_idx];
    end

    assign rd_x   = rd_q.x;
    assign rd_y   = rd_q.y;
    assign rd_en  = rd_q.en;
    assign rd_img = rd_q.img;

endmodule

// File: tb/tb_sprite_regs.sv
// Self-checking bench for sprite_regs: directed scenarios plus randomized traffic
// against a pending-commit / copy-cursor reference model.
module tb_sprite_regs;

    localparam int NUM = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_write = 1'b0;
    logic [3:0] in_command = 4'h0;
    logic [9:0] in_data = 10'h0;
    logic       vblank = 1'b0;
    logic [2:0] rd_idx = 3'd0;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       rd_en;
    logic [3:0] rd_img;
    logic       commit_pending;
    logic       copy_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: shadow/active tables, selected slot, a pending-commit flag
    // and the index of the next slot to copy (-1 when no copy is running).
    bit [9:0] s_x [NUM];
    bit [9:0] s_y [NUM];
    bit       s_en [NUM];
    bit [3:0] s_img [NUM];
    bit [9:0] a_x [NUM];
    bit [9:0] a_y [NUM];
    bit       a_en [NUM];
    bit [3:0] a_img [NUM];
    int       m_sel;
    int       m_pos;
    bit       m_want;
    bit       m_vbq;
    bit [9:0] e_x;
    bit [9:0] e_y;
    bit       e_en;
    bit [3:0] e_img;

    sprite_regs #(
        .NUM_SPRITES(NUM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_write      (in_write),
        .in_command    (in_command),
        .in_data       (in_data),
        .vblank        (vblank),
        .rd_idx        (rd_idx),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_en         (rd_en),
        .rd_img        (rd_img),
        .commit_pending(commit_pending),
        .copy_busy     (copy_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            s_x[i] = '0; s_y[i] = '0; s_en[i] = 1'b0; s_img[i] = '0;
            a_x[i] = '0; a_y[i] = '0; a_en[i] = 1'b0; a_img[i] = '0;
        end
        m_sel = 0; m_pos = -1; m_want = 1'b0; m_vbq = 1'b0;
        e_x = '0; e_y = '0; e_en = 1'b0; e_img = '0;
    endtask

    task automatic model_edge();
        bit copying;
        bit armed;
        bit rise;
        int ri;
        if (!rst_n) begin
            model_reset();
            return;
        end
        copying = (m_pos >= 0);
        armed   = m_want && !copying;
        rise    = vblank && !m_vbq;
        ri      = int'(rd_idx);
        e_x = a_x[ri]; e_y = a_y[ri]; e_en = a_en[ri]; e_img = a_img[ri];
        if (copying) begin
            a_x[m_pos] = s_x[m_pos]; a_y[m_pos] = s_y[m_pos];
            a_en[m_pos] = s_en[m_pos]; a_img[m_pos] = s_img[m_pos];
            m_pos++;
            if (m_pos == NUM) m_pos = -1;
        end else if (armed && rise) begin
            m_pos  = 0;
            m_want = 1'b0;
        end
        if (in_write) begin
            case (in_command)
                4'h1: m_sel = int'(in_data) % NUM;
                4'h2: s_x[m_sel] = in_data;
                4'h3: s_y[m_sel] = in_data;
                4'h4: s_en[m_sel] = in_data[0];
                4'h5: begin
                    s_img[m_sel] = in_data[3:0];
`ifdef SPRITE_REGS_AUTOINC_EN
                    m_sel = (m_sel + 1) % NUM;
`endif
                end
                4'hF: if (!armed) m_want = 1'b1;
                default: ;
            endcase
        end
        m_vbq = vblank;
    endtask

    task automatic compare();
        check("rd_x", 32'(rd_x), 32'(e_x));
        check("rd_y", 32'(rd_y), 32'(e_y));
        check("rd_en", 32'(rd_en), 32'(e_en));
        check("rd_img", 32'(rd_img), 32'(e_img));
        check("commit_pending", 32'(commit_pending), 32'(m_want || (m_pos >= 0)));
        check("copy_busy", 32'(copy_busy), 32'(m_pos >= 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic cmd(input logic [3:0] c, input logic [9:0] d);
        in_write = 1'b1; in_command = c; in_data = d;
        tick();
        in_write = 1'b0; in_command = 4'h0; in_data = '0;
    endtask

    task automatic read_check(input logic [2:0] idx, input string tag,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic en, input logic [3:0] img);
        rd_idx = idx;
        tick();
        check({tag, "_x"}, 32'(rd_x), 32'(x));
        check({tag, "_y"}, 32'(rd_y), 32'(y));
        check({tag, "_en"}, 32'(rd_en), 32'(en));
        check({tag, "_img"}, 32'(rd_img), 32'(img));
    endtask

    initial begin
        int cnt;
        model_reset();

        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_pending", 32'(commit_pending), 32'd0);
        check("rst_busy", 32'(copy_busy), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NUM; i++) read_check(3'(i), "rst_read", '0, '0, 1'b0, '0);

        // Shadow writes without COMMIT never reach the active table.
        cmd(4'h1, 10'd3);
        cmd(4'h2, 10'h123);
        cmd(4'h3, 10'h045);
        cmd(4'h4, 10'h001);
        cmd(4'h1, 10'd3);
        cmd(4'h5, 10'h007);
        for (int k = 0; k < 3; k++) begin
            vblank = 1'b1; repeat (2) tick();
            vblank = 1'b0; repeat (2) tick();
        end
        read_check(3'd3, "nocommit", '0, '0, 1'b0, '0);

        // COMMIT then vblank rise: copy lasts exactly NUM cycles.
        cmd(4'hF, 10'h0);
        check("armed_pending", 32'(commit_pending), 32'd1);
        vblank = 1'b1;
        tick();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!copy_busy) break;
            cnt++;
            tick();
        end
        check("busy_len", 32'(cnt), 32'(NUM));
        check("pending_after", 32'(commit_pending), 32'd0);
        read_check(3'd3, "commit3", 10'h123, 10'h045, 1'b1, 4'h7);

        // Writes during a copy: slot 0 already copied, slot 7 not yet.
        vblank = 1'b0; tick();
        cmd(4'hF, 10'h0);
        vblank = 1'b1; tick();
        cmd(4'h1, 10'd0);
        cmd(4'h2, 10'h2AA);
        cmd(4'h1, 10'd7);
        cmd(4'h2, 10'h155);
        repeat (6) tick();
        vblank = 1'b0;
        read_check(3'd0, "midcopy0", '0, '0, 1'b0, '0);
        read_check(3'd7, "midcopy7", 10'h155, '0, 1'b0, '0);

        // COMMIT during COPY re-arms; the next vblank edge copies again.
        cmd(4'hF, 10'h0);
        vblank = 1'b1; tick();
        repeat (2) tick();
        cmd(4'hF, 10'h0);
        repeat (8) tick();
        check("rearm_pending", 32'(commit_pending), 32'd1);
        check("rearm_idle", 32'(copy_busy), 32'd0);
        vblank = 1'b0; tick();
        vblank = 1'b1; tick();
        check("second_copy", 32'(copy_busy), 32'd1);
        read_check(3'd0, "second0", 10'h2AA, '0, 1'b0, '0);

        // Reset in the middle of a copy clears everything.
        rst_n = 1'b0; vblank = 1'b0; tick();
        rst_n = 1'b1;
        check("midrst_pending", 32'(commit_pending), 32'd0);
        check("midrst_busy", 32'(copy_busy), 32'd0);
        read_check(3'd3, "midrst3", '0, '0, 1'b0, '0);

        // SET_IMG on slot 7 followed by SET_X.
        cmd(4'h1, 10'h3F7);
        cmd(4'h5, 10'h002);
        cmd(4'h2, 10'h005);
        cmd(4'hF, 10'h0);
        vblank = 1'b1; tick();
        repeat (9) tick();
        vblank = 1'b0;
`ifdef SPRITE_REGS_AUTOINC_EN
        read_check(3'd0, "autoinc0", 10'h005, '0, 1'b0, '0);
        read_check(3'd7, "autoinc7", '0, '0, 1'b0, 4'h2);
`else
        read_check(3'd0, "noinc0", '0, '0, 1'b0, '0);
        read_check(3'd7, "noinc7", 10'h005, '0, 1'b0, 4'h2);
`endif

        for (int n = 0; n < 4000; n++) begin
            rst_n      = ($urandom_range(0, 699) != 0);
            in_write   = 1'($urandom_range(0, 1));
            in_command = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            in_data    = 10'($urandom);
            if ($urandom_range(0, 11) == 0) vblank = ~vblank;
            rd_idx     = 3'($urandom_range(0, NUM - 1));
            tick();
        end
        rst_n = 1'b1; in_write = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
